// File: rtl/led_fade_driver.sv
// ============================================================================
// Module   : led_fade_driver
// Brief    : Per-LED PWM fader; pattern bits ramp brightness up/down per period.
//            Optional macro LED_FADE_ACTIVE_LOW_EN inverts LED_o (reset all ones).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fade_driver #(
  parameter int LED_NUM = 8,
  parameter int PWM_W   = 8,
  parameter int PRESC   = 1172,
  parameter int STEP    = 16
) (
  input  logic               CLK_i,
  input  logic               RSTn_i,
  input  logic [LED_NUM-1:0] LED_i,
  output logic [LED_NUM-1:0] LED_o,
  output logic               BUSY_o
);

  localparam int                  c_PCNT_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(PRESC - 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_ONE  = c_PCNT_W'(1);
  localparam logic [PWM_W-1:0]    c_PWM_LAST  = '1;
  localparam logic [PWM_W-1:0]    c_PWM_ONE   = PWM_W'(1);
  localparam logic [PWM_W+1:0]    c_MAX       = (PWM_W+2)'(2**PWM_W);
  localparam logic [PWM_W:0]      c_MAX_B     = c_MAX[PWM_W:0];
  localparam logic [PWM_W+1:0]    c_STEP      = (PWM_W+2)'(STEP);
  localparam logic [PWM_W:0]      c_STEP_B    = c_STEP[PWM_W:0];

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam logic [LED_NUM-1:0]  c_LED_POL   = '1;
`else
  localparam logic [LED_NUM-1:0]  c_LED_POL   = '0;
`endif

  logic [LED_NUM-1:0]  r_sync;
  logic [LED_NUM-1:0]  r_tgt;
  logic [c_PCNT_W-1:0] r_pcnt;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic [LED_NUM-1:0]  r_led;
  logic                r_busy;
  logic                w_tick;
  logic                w_period_end;
  logic [LED_NUM-1:0]  w_duty;
  logic [LED_NUM-1:0]  w_diff;

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_sync <= '0;
      r_tgt  <= '0;
    end else begin
      r_sync <= LED_i;
      r_tgt  <= r_sync;
    end
  end

  assign w_tick       = (r_pcnt == c_PCNT_LAST);
  assign w_period_end = w_tick && (r_pwm_cnt == c_PWM_LAST);

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : (r_pcnt + c_PCNT_ONE);
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
      end
    end
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_led
    logic [PWM_W:0]   r_bright;
    logic [PWM_W+1:0] w_ext;
    logic [PWM_W+1:0] w_up;
    logic [PWM_W:0]   w_dn;
    logic [PWM_W+1:0] w_lvl;
    logic [PWM_W:0]   w_next;

    // one extra bit of headroom keeps bright+STEP from wrapping before the clamp
    assign w_ext = {1'b0, r_bright};
    assign w_up  = w_ext + c_STEP;
    assign w_dn  = r_bright - c_STEP_B;
    assign w_lvl = r_tgt[i] ? c_MAX : '0;

    always_comb begin
      w_next = r_bright;
      if (r_tgt[i]) begin
        w_next = (w_up >= c_MAX) ? c_MAX_B : w_up[PWM_W:0];
      end else begin
        w_next = (w_ext <= c_STEP) ? '0 : w_dn;
      end
    end

    always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
        r_bright <= '0;
      end else if (w_period_end) begin
        r_bright <= w_next;
      end
    end

    assign w_duty[i] = ({1'b0, r_pwm_cnt} < r_bright);
    assign w_diff[i] = (w_ext != w_lvl);
  end

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_led  <= c_LED_POL;
      r_busy <= 1'b0;
    end else begin
      r_led  <= w_duty ^ c_LED_POL;
      r_busy <= |w_diff;
    end
  end

  assign LED_o  = r_led;
  assign BUSY_o = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_driver.sv
// ============================================================================
// Module   : tb_led_fade_driver
// Brief    : Self-checking bench for led_fade_driver (STEP=4 and STEP=5 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fade_driver;

  localparam int PWM_W = 4;
  localparam int PRESC = 2;
  localparam int MAXB  = 16;
  localparam int PER   = PRESC * MAXB;

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam logic [7:0] c_POL = 8'hFF;
`else
  localparam logic [7:0] c_POL = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_in;
  logic [7:0] led4, led5;
  logic       busy4, busy5;

  always #5 clk = ~clk;

  led_fade_driver #(.LED_NUM(8), .PWM_W(PWM_W), .PRESC(PRESC), .STEP(4)) dut4 (
    .CLK_i(clk), .RSTn_i(rst_n), .LED_i(led_in), .LED_o(led4), .BUSY_o(busy4)
  );

  led_fade_driver #(.LED_NUM(8), .PWM_W(PWM_W), .PRESC(PRESC), .STEP(5)) dut5 (
    .CLK_i(clk), .RSTn_i(rst_n), .LED_i(led_in), .LED_o(led5), .BUSY_o(busy5)
  );

  int         tests = 0;
  int         fails = 0;
  int         b4[8];
  int         b5[8];
  logic [7:0] cur_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int b, input logic t, input int step);
    if (t) return (b + step >= MAXB) ? MAXB : b + step;
    return (b <= step) ? 0 : b - step;
  endfunction

  function automatic logic exp_busy(input logic [7:0] t, input logic sel5);
    logic r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r |= ((sel5 ? b5[i] : b4[i]) != (t[i] ? MAXB : 0));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      b4[i] = 0;
      b5[i] = 0;
    end
    cur_tgt = 8'h00;
  endtask

  // One full PWM period; entered on the negedge right after a period boundary.
  // LED_i shows 'pulse' mid-period and settles to 'val' well before the boundary.
  task automatic run_period(input logic [7:0] val, input logic [7:0] pulse);
    int c4[8];
    int c5[8];
    for (int i = 0; i < 8; i++) begin
      c4[i] = 0;
      c5[i] = 0;
    end
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("busy4_start", busy4, exp_busy(cur_tgt, 1'b0));
        check("busy5_start", busy5, exp_busy(cur_tgt, 1'b1));
      end
      for (int i = 0; i < 8; i++) begin
        c4[i] += int'(led4[i] ^ c_POL[i]);
        c5[i] += int'(led5[i] ^ c_POL[i]);
      end
      if (j == 4)  led_in = pulse;
      if (j == 12) led_in = val;
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("duty4[%0d]", i), c4[i], PRESC * b4[i]);
      check($sformatf("duty5[%0d]", i), c5[i], PRESC * b5[i]);
    end
    cur_tgt = val;
    check("busy4_end", busy4, exp_busy(val, 1'b0));
    check("busy5_end", busy5, exp_busy(val, 1'b1));
    for (int i = 0; i < 8; i++) begin
      b4[i] = nxt(b4[i], val[i], 4);
      b5[i] = nxt(b5[i], val[i], 5);
    end
  endtask

  initial begin
    logic [7:0] walk;
    rst_n  = 1'b0;
    led_in = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_led4", led4, c_POL);
    check("rst_led5", led5, c_POL);
    check("rst_busy4", busy4, 1'b0);
    check("rst_busy5", busy5, 1'b0);
    rst_n = 1'b1;

    repeat (6) run_period(8'h01, 8'h01);
    repeat (6) run_period(8'h00, 8'h00);

    walk = 8'h01;
    repeat (4) begin
      run_period(walk, walk);
      walk = walk << 1;
    end
    repeat (5) run_period(8'h00, 8'h00);

    // asynchronous reset while ramping, between clock edges
    run_period(8'hFF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_led4", led4, 8'hFF ^ c_POL);
    check("pre_rst_busy4", busy4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led4", led4, c_POL);
    check("async_rst_led5", led5, c_POL);
    check("async_rst_busy4", busy4, 1'b0);
    check("async_rst_busy5", busy5, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    repeat (14) run_period(8'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
